// File: rtl/ft245_fifo_responder_if.sv
// Signal bundle between the 68000 FT245-style bus glue, the byte-stream bridge and the responder.
// The bidirectional data bus da stays a plain inout port on the responder.
interface ft245_fifo_responder_if;
    logic       _rd;
    logic       wr;
    logic       _rdf;
    logic       _txe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       overflow;
    logic       underflow;

    modport slave (
        input  _rd, wr, rx_data, rx_valid, tx_ready,
        output _rdf, _txe, rx_ready, tx_data, tx_valid, overflow, underflow
    );

    modport master (
        output _rd, wr, rx_data, rx_valid, tx_ready,
        input  _rdf, _txe, rx_ready, tx_data, tx_valid, overflow, underflow
    );
endinterface

// File: rtl/ft245_fifo_responder.sv
// FT245-style FIFO port responder: CPU reads pop the RX FIFO, CPU writes push the TX FIFO.
// Asynchronous strobes are synchronised and edge-detected in clk.
module ft245_fifo_responder #(
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  _reset,
    ft245_fifo_responder_if.slave bus,
    inout  wire  [7:0]            da
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned GW    = $clog2(GAP_CYCLES + 1);

    typedef enum logic {READY, GAP} flag_state_e;
    typedef logic [DEPTH_LOG2:0] ptr_t;

    logic [SYNC_STAGES-1:0] rd_sync, wr_sync;
    logic                   rd_s, wr_s, rd_d, wr_d;
    logic [7:0]             da_s, wr_hold, rd_head;
    logic                   alive;
    logic [7:0]             rx_mem [DEPTH];
    logic [7:0]             tx_mem [DEPTH];
    ptr_t                   rx_wp, rx_rp, tx_wp, tx_rp;
    logic                   rx_empty, rx_full, tx_empty, tx_full;
    logic                   cpu_pop, cpu_push, rx_push, rx_pop, tx_push, tx_pop;
    flag_state_e            rx_st, tx_st;
    logic [GW-1:0]          rx_cnt, tx_cnt;
    logic                   rdf_q, txe_q, over_q, under_q;

    assign rd_s     = rd_sync[SYNC_STAGES-1];
    assign wr_s     = wr_sync[SYNC_STAGES-1];
    assign cpu_pop  = rd_s & ~rd_d;
    assign cpu_push = wr_d & ~wr_s;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[DEPTH_LOG2] != rx_rp[DEPTH_LOG2]) &&
                      (rx_wp[DEPTH_LOG2-1:0] == rx_rp[DEPTH_LOG2-1:0]);
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[DEPTH_LOG2] != tx_rp[DEPTH_LOG2]) &&
                      (tx_wp[DEPTH_LOG2-1:0] == tx_rp[DEPTH_LOG2-1:0]);

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign rx_push = bus.rx_valid & bus.rx_ready;
    assign rx_pop  = cpu_pop & ~rx_empty;
    assign tx_pop  = bus.tx_valid & bus.tx_ready;
    assign tx_push = cpu_push & (~tx_full | tx_pop);

    assign bus.rx_ready  = alive & ~rx_full;
    assign bus.tx_valid  = ~tx_empty;
    assign bus.tx_data   = tx_mem[tx_rp[DEPTH_LOG2-1:0]];
    assign bus._rdf      = rdf_q;
    assign bus._txe      = txe_q;
    assign bus.overflow  = over_q;
    assign bus.underflow = under_q;

    assign da = (~bus._rd & _reset) ? rd_head : 'z;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[DEPTH_LOG2-1:0]] <= bus.rx_data;
        if (tx_push) tx_mem[tx_wp[DEPTH_LOG2-1:0]] <= wr_hold;
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            rd_sync <= '1;
            wr_sync <= '0;
            rd_d    <= 1'b1;
            wr_d    <= 1'b0;
            da_s    <= '0;
            wr_hold <= '0;
            rd_head <= '1;
            alive   <= 1'b0;
            rx_wp   <= '0;
            rx_rp   <= '0;
            tx_wp   <= '0;
            tx_rp   <= '0;
            rx_st   <= READY;
            tx_st   <= READY;
            rx_cnt  <= '0;
            tx_cnt  <= '0;
            rdf_q   <= 1'b1;
            txe_q   <= 1'b1;
            over_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            rd_sync[0] <= bus._rd;
            wr_sync[0] <= bus.wr;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= rd_sync[i-1];
                wr_sync[i] <= wr_sync[i-1];
            end
            rd_d  <= rd_s;
            wr_d  <= wr_s;
            da_s  <= da;
            alive <= 1'b1;
            // Freeze the write byte once synced wr drops so the push sees the strobed value.
            if (wr_s) wr_hold <= da_s;
            rd_head <= rx_empty ? 8'hFF : rx_mem[rx_rp[DEPTH_LOG2-1:0]];

            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;

            if (cpu_pop && rx_empty)             under_q <= 1'b1;
            if (cpu_push && tx_full && !tx_pop)  over_q  <= 1'b1;

            if (cpu_pop) begin
                rx_st  <= GAP;
                rx_cnt <= GW'(GAP_CYCLES - 1);
                rdf_q  <= 1'b1;
            end else if (rx_st == GAP) begin
                if (rx_cnt == '0) begin
                    rx_st <= READY;
                    rdf_q <= rx_empty;
                end else begin
                    rx_cnt <= rx_cnt - 1'b1;
                    rdf_q  <= 1'b1;
                end
            end else begin
                rdf_q <= rx_empty;
            end

            if (cpu_push) begin
                tx_st  <= GAP;
                tx_cnt <= GW'(GAP_CYCLES - 1);
                txe_q  <= 1'b1;
            end else if (tx_st == GAP) begin
                if (tx_cnt == '0) begin
                    tx_st <= READY;
                    txe_q <= tx_full;
                end else begin
                    tx_cnt <= tx_cnt - 1'b1;
                    txe_q  <= 1'b1;
                end
            end else begin
                txe_q <= tx_full;
            end
        end
    end
endmodule

// File: tb/tb_ft245_fifo_responder.sv
// Bench for ft245_fifo_responder: queue-based model of both FIFOs and sticky flags,
// table-driven CPU writes plus hand-written timing sequences.
module tb_ft245_fifo_responder;
    logic       clk = 1'b0;
    logic       _reset = 1'b0;
    logic       cpu_oe = 1'b0;
    logic [7:0] cpu_data = '0;
    tri0  [7:0] da;

    assign da = cpu_oe ? cpu_data : 'z;

    ft245_fifo_responder_if bus();

    ft245_fifo_responder #(.DEPTH_LOG2(4), .SYNC_STAGES(2), .GAP_CYCLES(2)) dut (
        .clk(clk), ._reset(_reset), .bus(bus), .da(da)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    byte unsigned rx_q[$];
    byte unsigned tx_q[$];
    bit m_over = 1'b0;
    bit m_under = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       exp_txe;
        logic       exp_over;
    } wvec_t;
    wvec_t wv[17];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshakes seen at the falling edge complete at the following rising edge.
    always @(negedge clk) begin
        if (_reset) begin
            if (bus.rx_valid && bus.rx_ready) rx_q.push_back(bus.rx_data);
            if (bus.tx_valid && bus.tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %0h expected no byte", bus.tx_data);
                end else begin
                    check("tx_order", bus.tx_data, tx_q.pop_front());
                end
            end
        end
    end

    task automatic cpu_write(input logic [7:0] b);
        cpu_data = b;
        cpu_oe   = 1'b1;
        bus.wr   = 1'b1;
        repeat (3) tick();
        bus.wr = 1'b0;
        if (tx_q.size() >= 16 && !bus.tx_ready) m_over = 1'b1;
        else tx_q.push_back(b);
        repeat (3) tick();
        cpu_oe = 1'b0;
        tick();
    endtask

    task automatic read_and_check(input string name);
        logic [7:0] exp;
        exp = (rx_q.size() != 0) ? rx_q[0] : 8'hFF;
        bus._rd = 1'b0;
        repeat (3) tick();
        check(name, da, exp);
        tick();
        bus._rd = 1'b1;
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        else m_under = 1'b1;
        repeat (5) tick();
    endtask

    task automatic stream_push(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        check("rx_push_accepted", ok, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int rdf_exp[5];
        int txe_exp[6];
        rdf_exp = '{0, 0, 1, 1, 1};
        txe_exp = '{0, 0, 1, 1, 0, 0};

        bus._rd = 1'b1;
        bus.wr = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = '0;
        bus.tx_ready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_rdf", bus._rdf, 1);
        check("rst_txe", bus._txe, 1);
        check("rst_rx_ready", bus.rx_ready, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_underflow", bus.underflow, 0);
        check("rst_da_z", da, 8'h00);
        _reset = 1'b1;
        tick();
        check("rel_txe", bus._txe, 0);
        check("rel_rx_ready", bus.rx_ready, 1);
        check("rel_rdf", bus._rdf, 1);
        check("rel_tx_valid", bus.tx_valid, 0);
        check("rel_da_z", da, 8'h00);

        // Stream byte 0x41, then a CPU read pulse
        bus.rx_data = 8'h41;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        check("rdf_edge_n", bus._rdf, 1);
        tick();
        check("rdf_edge_n1", bus._rdf, 0);
        bus._rd = 1'b0;
        tick();
        check("da_0x41", da, 8'h41);
        repeat (3) tick();
        bus._rd = 1'b1;
        void'(rx_q.pop_front());
        for (int e = 0; e < 5; e++) begin
            tick();
            check("rdf_after_pop", bus._rdf, rdf_exp[e]);
        end
        check("da_z_idle", da, 8'h00);
        check("underflow_clear", bus.underflow, 0);

        // Two CPU writes drained immediately, watching the _txe gap
        bus.tx_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            b = (j == 0) ? 8'h55 : 8'hAA;
            cpu_data = b;
            cpu_oe = 1'b1;
            bus.wr = 1'b1;
            repeat (3) tick();
            bus.wr = 1'b0;
            tx_q.push_back(b);
            for (int e = 0; e < 6; e++) begin
                tick();
                check("txe_gap", bus._txe, txe_exp[e]);
            end
            cpu_oe = 1'b0;
            tick();
        end
        check("tx_drained", tx_q.size(), 0);
        check("overflow_none", bus.overflow, 0);
        bus.tx_ready = 1'b0;

        // 17 writes into a stalled TX FIFO
        for (int i = 0; i < 17; i++) begin
            wv[i].data     = 8'($urandom);
            wv[i].exp_txe  = (i >= 15);
            wv[i].exp_over = (i == 16);
        end
        for (int i = 0; i < 17; i++) begin
            cpu_write(wv[i].data);
            repeat (3) tick();
            check("fill_txe", bus._txe, wv[i].exp_txe);
            check("fill_overflow", bus.overflow, wv[i].exp_over);
        end
        check("model_overflow", bus.overflow, m_over);
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 100 && bus.tx_valid; k++) tick();
        bus.tx_ready = 1'b0;
        check("drain_tx_valid", bus.tx_valid, 0);
        check("drain_count", tx_q.size(), 0);

        // Read with RX empty, then confirm pointers were not disturbed
        read_and_check("da_empty");
        check("underflow_set", bus.underflow, m_under);
        b = 8'($urandom);
        stream_push(b);
        read_and_check("da_after_underflow");

        // Fill RX with random traffic, then pop and push together at full
        for (int i = 0; i < 16; i++) begin
            stream_push(8'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end
        tick();
        check("rx_full_ready", bus.rx_ready, 0);
        check("rx_full_count", rx_q.size(), 16);
        check("rx_full_rdf", bus._rdf, 0);
        fork
            stream_push(8'($urandom));
            read_and_check("da_pop_at_full");
        join
        tick();
        check("rx_refull_ready", bus.rx_ready, 0);
        check("rx_refull_count", rx_q.size(), 16);
        for (int i = 0; i < 8; i++) read_and_check("da_drain");

        // TX half full too, then reset in the middle of a read
        for (int i = 0; i < 8; i++) cpu_write(8'($urandom));
        check("half_tx_valid", bus.tx_valid, 1);
        bus._rd = 1'b0;
        repeat (2) tick();
        _reset = 1'b0;
        #2;
        check("mid_rst_da_z", da, 8'h00);
        check("mid_rst_rdf", bus._rdf, 1);
        check("mid_rst_txe", bus._txe, 1);
        check("mid_rst_rx_ready", bus.rx_ready, 0);
        check("mid_rst_tx_valid", bus.tx_valid, 0);
        check("mid_rst_overflow", bus.overflow, 0);
        check("mid_rst_underflow", bus.underflow, 0);
        rx_q.delete();
        tx_q.delete();
        m_over = 1'b0;
        m_under = 1'b0;
        bus._rd = 1'b1;
        tick();
        _reset = 1'b1;
        tick();
        check("post_rst_rx_ready", bus.rx_ready, 1);
        check("post_rst_txe", bus._txe, 0);
        check("post_rst_rdf", bus._rdf, 1);
        check("post_rst_tx_valid", bus.tx_valid, 0);
        read_and_check("post_rst_da_empty");
        check("post_rst_underflow", bus.underflow, m_under);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
